sum_seg_display: RTL and testbench
==================================

# sum_seg_display

Downstream display stage for the 4-bit adder. It captures the registered 5-bit sum (carry plus 4-bit result) when the adder strobes it, converts it to two decimal digits and shows them one at a time on the single 7-segment display. The tens digit is shown first, the ones digit last, with a blank gap after each, repeating until a new sum arrives. Leading-zero tens digits are suppressed.

## Interface
- DIGIT_CYCLES, default 12_000_000: cycles each digit is lit; must be ≥1.
- BLANK_CYCLES, default 3_000_000: cycles of blank after each digit; must be ≥1.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sum_in  in  5  unsigned sum from adder, {cout, sum[3:0]}, range 0..31.
- sum_valid  in  1  one-cycle strobe; sum_in is valid in that cycle.
- seg_out  out  7  active-high segments {g,f,e,d,c,b,a}; bit0 = a.
- dp_out  out  1  decimal point; high while the ones digit is lit.
- active  out  1  high in every state except IDLE.

## Operation
- States: IDLE, TENS, GAP_T, ONES, GAP_O.
- Registers:
  - value[4:0]: latched sum.
  - cnt: phase counter, width $clog2(max(DIGIT_CYCLES, BLANK_CYCLES)+1).
- Decimal conversion from value:
  - tens = 3 if value≥30, 2 if ≥20, 1 if ≥10, else 0.
  - ones = value − 10·tens; always 0..9.
- Segment patterns (hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Blank = 00.
- seg_out and dp_out are registered, updated on the same edge as the state.
- IDLE: seg_out=00, dp_out=0. Left only on sum_valid.
- On sum_valid (any state):
  - value<=sum_in and cnt<=0.
  - Next state is TENS if sum_in≥10, else ONES.
  - seg_out shows the new digit immediately.
- TENS: seg_out=pattern(tens), dp_out=0. After DIGIT_CYCLES cycles, go to GAP_T.
- GAP_T: blank. After BLANK_CYCLES cycles, go to ONES.
- ONES: seg_out=pattern(ones), dp_out=1. After DIGIT_CYCLES cycles, go to GAP_O.
- GAP_O: blank. After BLANK_CYCLES cycles, go to TENS if value≥10, else ONES.
- cnt resets to 0 on every state change. A state lasts exactly its programmed cycle count.
- sum_valid has priority over the counter expiry in the same cycle.
- sum_valid with an unchanged value still restarts the sequence.
- sum_in is ignored when sum_valid=0.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, value=0, cnt=0, seg_out=00, dp_out=0, active=0.
- Latency: sum_valid sampled at edge k gives the first digit on seg_out and active=1 after edge k.
- Sequence period:
  - value≥10: 2·(DIGIT_CYCLES+BLANK_CYCLES).
  - value<10: DIGIT_CYCLES+BLANK_CYCLES.
- Reset asserted mid-sequence: outputs go to reset values immediately, with no wait for clk. The latched value is lost, and the block stays in IDLE until the next sum_valid.
- No glitches on seg_out: all outputs come straight from flops.

## Test plan
All scenarios use DIGIT_CYCLES=4, BLANK_CYCLES=2.
- Reset, no strobe for 50 cycles -> seg_out=00, dp_out=0, active=0 throughout.
- sum_valid with sum_in=23 -> seg_out=5B for 4 cycles, 00 for 2, 4F with dp_out=1 for 4, 00 for 2; then repeats with period 12.
- sum_valid with sum_in=7 -> seg_out=07 with dp_out=1 for 4 cycles, 00 for 2; period 6; tens digit never shown. sum_in=0 -> 3F with the same timing.
- sum_in=31 -> 4F (tens=3) for 4 cycles, then 06 (ones=1). sum_in=30 -> 4F, then 3F.
- sum_valid with 15 arrives in the 3rd cycle of ONES for value 23 -> next cycle seg_out=06 (tens of 15) for a full 4 cycles, then the sequence for 15. A strobe coincident with the GAP_O expiry also restarts the sequence.
- rst_n pulled low mid-TENS between clock edges -> seg_out=00 and active=0 immediately. After release, the block stays IDLE until a strobe.

Source files
------------

// File: rtl/sum_seg_display_if.sv
// Bus between the adder/testbench and the seven-segment display stage.
// The master side strobes in a sum, and the slave side drives the display.
interface sum_seg_display_if;
  logic [4:0] sum_in;
  logic       sum_valid;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       active;

  modport master (
    output sum_in,
    output sum_valid,
    input  seg_out,
    input  dp_out,
    input  active
  );

  modport slave (
    input  sum_in,
    input  sum_valid,
    output seg_out,
    output dp_out,
    output active
  );
endinterface

// File: rtl/sum_seg_display.sv
// Shows a latched 0..31 sum on one seven-segment display.
// The tens digit is shown first and the ones digit last, each followed by a blank gap.
module sum_seg_display #(
  parameter int DIGIT_CYCLES = 12_000_000,
  parameter int BLANK_CYCLES = 3_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  sum_seg_display_if.slave   bus
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, TENS, GAP_T, ONES, GAP_O} state_t;

  state_t           r_state, w_nextState;
  logic [4:0]       r_value, w_nextValue;
  logic [CNT_W-1:0] r_cnt, w_nextCnt;
  logic [6:0]       r_seg, w_nextSeg;
  logic             r_dp, w_nextDp;
  logic             r_active;
  logic [1:0]       w_tens;
  logic [4:0]       w_tensTimesTen;
  logic [4:0]       w_onesWide;
  logic [3:0]       w_ones;

  function automatic logic [6:0] segPattern(input logic [3:0] digit);
    case (digit)
      4'd0:    segPattern = 7'h3F;
      4'd1:    segPattern = 7'h06;
      4'd2:    segPattern = 7'h5B;
      4'd3:    segPattern = 7'h4F;
      4'd4:    segPattern = 7'h66;
      4'd5:    segPattern = 7'h6D;
      4'd6:    segPattern = 7'h7D;
      4'd7:    segPattern = 7'h07;
      4'd8:    segPattern = 7'h7F;
      4'd9:    segPattern = 7'h6F;
      default: segPattern = 7'h00;
    endcase
  endfunction

  // Next state and value. A strobe takes priority over any counter expiry.
  always_comb begin
    w_nextState = r_state;
    w_nextValue = r_value;
    w_nextCnt   = r_cnt + CNT_W'(1);
    if (bus.sum_valid) begin
      w_nextValue = bus.sum_in;
      w_nextCnt   = '0;
      w_nextState = (bus.sum_in >= 5'd10) ? TENS : ONES;
    end else begin
      case (r_state)
        IDLE: w_nextCnt = '0;
        TENS: if (r_cnt == DIGIT_LAST) begin
          w_nextState = GAP_T;
          w_nextCnt   = '0;
        end
        GAP_T: if (r_cnt == BLANK_LAST) begin
          w_nextState = ONES;
          w_nextCnt   = '0;
        end
        ONES: if (r_cnt == DIGIT_LAST) begin
          w_nextState = GAP_O;
          w_nextCnt   = '0;
        end
        GAP_O: if (r_cnt == BLANK_LAST) begin
          w_nextState = (r_value >= 5'd10) ? TENS : ONES;
          w_nextCnt   = '0;
        end
        default: begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end
      endcase
    end
  end

  // Decode from the next value so that a new digit appears on the same edge that latches it.
  always_comb begin
    w_tens         = 2'd0;
    w_tensTimesTen = 5'd0;
    if (w_nextValue >= 5'd30) begin
      w_tens         = 2'd3;
      w_tensTimesTen = 5'd30;
    end else if (w_nextValue >= 5'd20) begin
      w_tens         = 2'd2;
      w_tensTimesTen = 5'd20;
    end else if (w_nextValue >= 5'd10) begin
      w_tens         = 2'd1;
      w_tensTimesTen = 5'd10;
    end
    w_onesWide = w_nextValue - w_tensTimesTen;
    w_ones     = w_onesWide[3:0];
    w_nextSeg  = 7'h00;
    w_nextDp   = 1'b0;
    case (w_nextState)
      TENS: w_nextSeg = segPattern({2'b00, w_tens});
      ONES: begin
        w_nextSeg = segPattern(w_ones);
        w_nextDp  = 1'b1;
      end
      default: begin
        w_nextSeg = 7'h00;
        w_nextDp  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_value  <= '0;
      r_cnt    <= '0;
      r_seg    <= 7'h00;
      r_dp     <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_value  <= w_nextValue;
      r_cnt    <= w_nextCnt;
      r_seg    <= w_nextSeg;
      r_dp     <= w_nextDp;
      r_active <= (w_nextState != IDLE);
    end
  end

  assign bus.seg_out = r_seg;
  assign bus.dp_out  = r_dp;
  assign bus.active  = r_active;

endmodule

// File: tb/tb_sum_seg_display.sv
// Directed bench for sum_seg_display with DIGIT_CYCLES=4 and BLANK_CYCLES=2.
// Every expected segment pattern and every run length is written out by hand.
module tb_sum_seg_display;

  logic clk;
  logic rst_n;
  int   vectorCount;
  int   missCount;

  sum_seg_display_if bus();

  sum_seg_display #(
    .DIGIT_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [6:0] seg, input logic dp, input logic act);
    logic [8:0] observed;
    logic [8:0] expected;
    observed = {bus.seg_out, bus.dp_out, bus.active};
    expected = {seg, dp, act};
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed seg/dp/active=%h/%b/%b, expected %h/%b/%b",
             tag, observed[8:2], observed[1], observed[0], seg, dp, act);
    end
  endtask

  // Called at a falling edge; checks n consecutive cycles and ends at the falling edge that follows them.
  task automatic expectRun(input string tag, input logic [6:0] seg, input logic dp, input logic act, input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput(tag, seg, dp, act);
      @(negedge clk);
    end
  endtask

  // Called at a falling edge; holds the strobe for exactly one rising edge.
  task automatic applyStimulus(input logic [4:0] value);
    bus.sum_in    = value;
    bus.sum_valid = 1'b1;
    @(negedge clk);
    bus.sum_valid = 1'b0;
  endtask

  initial begin
    vectorCount   = 0;
    missCount     = 0;
    rst_n         = 1'b0;
    bus.sum_in    = 5'd0;
    bus.sum_valid = 1'b0;
    #1;
    checkOutput("reset", 7'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.sum_in = 5'd23;
    expectRun("idle50", 7'h00, 1'b0, 1'b0, 50);

    $display("[TB] sum 23");
    applyStimulus(5'd23);
    expectRun("23tens", 7'h5B, 1'b0, 1'b1, 4);
    expectRun("23gapT", 7'h00, 1'b0, 1'b1, 2);
    expectRun("23ones", 7'h4F, 1'b1, 1'b1, 4);
    expectRun("23gapO", 7'h00, 1'b0, 1'b1, 2);
    expectRun("23tens2", 7'h5B, 1'b0, 1'b1, 4);
    expectRun("23gapT2", 7'h00, 1'b0, 1'b1, 2);

    $display("[TB] sum 7");
    applyStimulus(5'd7);
    expectRun("7ones", 7'h07, 1'b1, 1'b1, 4);
    expectRun("7gap", 7'h00, 1'b0, 1'b1, 2);
    expectRun("7ones2", 7'h07, 1'b1, 1'b1, 4);
    expectRun("7gap2", 7'h00, 1'b0, 1'b1, 2);

    $display("[TB] sum 0");
    applyStimulus(5'd0);
    expectRun("0ones", 7'h3F, 1'b1, 1'b1, 4);
    expectRun("0gap", 7'h00, 1'b0, 1'b1, 2);
    expectRun("0ones2", 7'h3F, 1'b1, 1'b1, 4);

    $display("[TB] sums 31 and 30");
    applyStimulus(5'd31);
    expectRun("31tens", 7'h4F, 1'b0, 1'b1, 4);
    expectRun("31gapT", 7'h00, 1'b0, 1'b1, 2);
    expectRun("31ones", 7'h06, 1'b1, 1'b1, 4);
    applyStimulus(5'd30);
    expectRun("30tens", 7'h4F, 1'b0, 1'b1, 4);
    expectRun("30gapT", 7'h00, 1'b0, 1'b1, 2);
    expectRun("30ones", 7'h3F, 1'b1, 1'b1, 4);

    $display("[TB] strobe during ONES and at GAP_O expiry");
    applyStimulus(5'd23);
    expectRun("r23tens", 7'h5B, 1'b0, 1'b1, 4);
    expectRun("r23gapT", 7'h00, 1'b0, 1'b1, 2);
    expectRun("r23ones", 7'h4F, 1'b1, 1'b1, 2);
    checkOutput("r23ones3", 7'h4F, 1'b1, 1'b1);
    applyStimulus(5'd15);
    expectRun("15tens", 7'h06, 1'b0, 1'b1, 4);
    expectRun("15gapT", 7'h00, 1'b0, 1'b1, 2);
    expectRun("15ones", 7'h6D, 1'b1, 1'b1, 4);
    expectRun("15gapO", 7'h00, 1'b0, 1'b1, 1);
    checkOutput("15gapOlast", 7'h00, 1'b0, 1'b1);
    applyStimulus(5'd7);
    expectRun("7restart", 7'h07, 1'b1, 1'b1, 4);
    expectRun("7restartGap", 7'h00, 1'b0, 1'b1, 2);

    $display("[TB] asynchronous reset mid-TENS");
    applyStimulus(5'd23);
    expectRun("preRst", 7'h5B, 1'b0, 1'b1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRst", 7'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    expectRun("postRstIdle", 7'h00, 1'b0, 1'b0, 10);
    applyStimulus(5'd31);
    expectRun("postRst31", 7'h4F, 1'b0, 1'b1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
